// File: rtl/sk6812_pkg.sv
// Shared definitions for the SK6812 frame scheduler.
// Holds the pixel word width, the GRB field offsets, the scheduler state
// encoding, the default latch length, and a width helper.
package sk6812_pkg;

  localparam int unsigned GRB_W = 24;

  // MSB position of each colour byte inside a GRB word.
  localparam int unsigned G_MSB = 23;
  localparam int unsigned R_MSB = 15;
  localparam int unsigned B_MSB = 7;

  // More than 80 us of low line at 12 MHz.
  localparam int unsigned LATCH_CYCLES_DEF = 1000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    LATCH
  } sched_state_e;

  // Counter width able to hold 0..n-1; never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sk6812_pixel_buf.sv
// Pixel store for the SK6812 chain: one GRB word per LED.
// Optional macro SK6812_DBUF_EN selects front/back buffering.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset (clears all words)
//   wr_en           - accepted host write
//   wr_addr, wr_grb - write address / data; addresses >= NUM_LEDS are dropped
//   copy            - copy back buffer to front buffer (SK6812_DBUF_EN only)
//   rd_idx, rd_grb  - combinational readout by LED index
module sk6812_pixel_buf
  import sk6812_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 2,
  parameter int unsigned AW       = 8,
  parameter int unsigned IW       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [GRB_W-1:0] wr_grb,
  input  logic             copy,
  input  logic [IW-1:0]    rd_idx,
  output logic [GRB_W-1:0] rd_grb
);

  // Host-facing words; this is the only buffer in the single-buffer build.
  logic [GRB_W-1:0] back_q [NUM_LEDS];

  // Out-of-range addresses match no entry, so they fall away here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        back_q[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (wr_addr == AW'(i)) begin
          back_q[i] <= wr_grb;
        end
      end
    end
  end

`ifdef SK6812_DBUF_EN
  logic [GRB_W-1:0] front_q [NUM_LEDS];

  // Copy samples back_q before any same-cycle write lands, so that write
  // only appears in the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        front_q[i] <= '0;
      end
    end else if (copy) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        front_q[i] <= back_q[i];
      end
    end
  end

  assign rd_grb = front_q[rd_idx];
`else
  logic unused_copy;
  assign unused_copy = copy;

  assign rd_grb = back_q[rd_idx];
`endif

endmodule

// File: rtl/sk6812_frame_sched.sv
// SK6812 frame scheduler: stores host pixels and, on frame_req, streams
// them in address order to the bit serializer, then holds the line idle
// for LATCH_CYCLES before signalling frame_done.
// Optional macro SK6812_DBUF_EN: front/back buffers, host writes never stall.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   wr_valid/wr_ready          - host write handshake
//   wr_addr, wr_grb            - LED index and GRB word ([23:16]=G,[15:8]=R,[7:0]=B)
//   frame_req                  - one-cycle refresh request
//   busy                       - frame in progress (through the latch gap)
//   frame_done                 - one-cycle pulse at end of latch gap
//   px_valid/px_ready          - pixel handshake to the serializer
//   px_data, px_last           - pixel word and final-pixel flag
module sk6812_frame_sched
  import sk6812_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = 2,
  parameter int unsigned AW           = 8,
  parameter int unsigned LATCH_CYCLES = LATCH_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [GRB_W-1:0] wr_grb,
  input  logic             frame_req,
  output logic             busy,
  output logic             frame_done,
  output logic             px_valid,
  input  logic             px_ready,
  output logic [GRB_W-1:0] px_data,
  output logic             px_last
);

  localparam int unsigned IW = clog2_min1(NUM_LEDS);
  localparam int unsigned CW = clog2_min1(LATCH_CYCLES);

  localparam logic [IW-1:0] LastIdx  = IW'(NUM_LEDS - 1);
  localparam logic [CW-1:0] LatchTop = CW'(LATCH_CYCLES - 1);

  sched_state_e     state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pvalid_q, pvalid_d;
  logic [GRB_W-1:0] pdata_q, pdata_d;
  logic             plast_q, plast_d;

  logic             copy;
  logic             wr_en;
  logic [GRB_W-1:0] rd_grb;

`ifdef SK6812_DBUF_EN
  assign wr_ready = 1'b1;
`else
  assign wr_ready = (state_q == IDLE);
`endif

  assign wr_en = wr_valid & wr_ready;

  sk6812_pixel_buf #(
    .NUM_LEDS (NUM_LEDS),
    .AW       (AW),
    .IW       (IW)
  ) u_pixel_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_grb  (wr_grb),
    .copy    (copy),
    .rd_idx  (idx_q),
    .rd_grb  (rd_grb)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pvalid_d = pvalid_q;
    pdata_d  = pdata_q;
    plast_d  = plast_q;
    copy     = 1'b0;

    // Requests during a frame coalesce into a single pending refresh.
    if (frame_req && (state_q != IDLE)) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (frame_req) begin
          idx_d   = '0;
          copy    = 1'b1;
          state_d = LOAD;
        end
      end

      LOAD: begin
        pdata_d  = rd_grb;
        plast_d  = (idx_q == LastIdx);
        pvalid_d = 1'b1;
        busy_d   = 1'b1;
        state_d  = SEND;
      end

      SEND: begin
        if (px_ready) begin
          pvalid_d = 1'b0;
          if (plast_q) begin
            cnt_d   = LatchTop;
            state_d = LATCH;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = LOAD;
          end
        end
      end

      LATCH: begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
          // A request arriving on this very cycle is folded into the restart
          // so it cannot be left pending while the scheduler sits in IDLE.
          if (pend_q || frame_req) begin
            pend_d  = 1'b0;
            idx_d   = '0;
            copy    = 1'b1;
            state_d = LOAD;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pvalid_q <= 1'b0;
      pdata_q  <= '0;
      plast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pvalid_q <= pvalid_d;
      pdata_q  <= pdata_d;
      plast_q  <= plast_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign px_valid   = pvalid_q;
  assign px_data    = pdata_q;
  assign px_last    = plast_q;

endmodule

// File: tb/tb_sk6812_frame_sched.sv
// Self-checking bench for sk6812_frame_sched (NUM_LEDS=2, short latch gap).
// Expected pixels are queued when a frame is requested; a monitor pops and
// compares on every pixel handshake and checks the frame_done gap.
module tb_sk6812_frame_sched;

  localparam int L = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_addr = '0;
  logic [23:0] wr_grb = '0;
  logic        frame_req = 1'b0;
  logic        busy;
  logic        frame_done;
  logic        px_valid;
  logic        px_ready = 1'b0;
  logic [23:0] px_data;
  logic        px_last;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          cyc = 0;
  int          last_hs = 0;
  logic [24:0] exp_q[$];
  logic [24:0] mon_e;

  sk6812_frame_sched #(
    .NUM_LEDS     (2),
    .AW           (8),
    .LATCH_CYCLES (L)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_grb     (wr_grb),
    .frame_req  (frame_req),
    .busy       (busy),
    .frame_done (frame_done),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .px_data    (px_data),
    .px_last    (px_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && px_valid && px_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pixel: got %06h last %0b expected none", px_data, px_last);
      end else begin
        mon_e = exp_q.pop_front();
        check("px_data", 32'(px_data), 32'(mon_e[23:0]));
        check("px_last", 32'(px_last), 32'(mon_e[24]));
      end
      if (px_last) last_hs = cyc;
    end
    if (rst_n && frame_done) begin
      n_done++;
      check("done_gap", 32'(cyc - last_hs), 32'(L + 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
  endtask

  task automatic push_frame(input logic [23:0] p0, input logic [23:0] p1);
    exp_q.push_back({1'b0, p0});
    exp_q.push_back({1'b1, p1});
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (n_done < target && k < 300) begin
      tick();
      k++;
    end
    check("frame_done_count", 32'(n_done), 32'(target));
  endtask

  task automatic host_write(input logic [7:0] a, input logic [23:0] d);
    int k;
    logic ok;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_grb   = d;
    k  = 0;
    ok = 1'b0;
    while (!ok && k < 300) begin
      @(negedge clk);
      ok = wr_ready;
      tick();
      k++;
    end
    wr_valid = 1'b0;
    check("write_accepted", 32'(ok), 32'(1));
  endtask

  initial begin
    int drops;
    int restarts;
    int k;
    logic ok;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_px_valid", 32'(px_valid), 32'(0));
    check("rst_frame_done", 32'(frame_done), 32'(0));
    check("rst_px_last", 32'(px_last), 32'(0));
    check("rst_px_data", 32'(px_data), 32'(0));
    check("rst_wr_ready", 32'(wr_ready), 32'(1));
    tick();
    rst_n = 1'b1;
    tick();

    // Basic frame: latency and ordering.
    host_write(8'd0, 24'h00FF00);
    host_write(8'd1, 24'h0000FF);
    px_ready = 1'b1;
    push_frame(24'h00FF00, 24'h0000FF);
    pulse_req();
    @(negedge clk);
    check("t1_busy", 32'(busy), 32'(0));
    check("t1_px_valid", 32'(px_valid), 32'(0));
    tick();
    @(negedge clk);
    check("t2_px_valid", 32'(px_valid), 32'(1));
    check("t2_busy", 32'(busy), 32'(1));
    wait_done(1);
    @(negedge clk);
    check("done_one_cycle", 32'(frame_done), 32'(0));
    check("idle_after_done", 32'(busy), 32'(0));
    tick();

    // Backpressure: 5 stalled cycles on pixel 0.
    px_ready = 1'b0;
    push_frame(24'h00FF00, 24'h0000FF);
    pulse_req();
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(px_valid), 32'(1));
      check("bp_data", 32'(px_data), 32'h00FF00);
      check("bp_last", 32'(px_last), 32'(0));
      tick();
    end
    px_ready = 1'b1;
    wait_done(2);

    // Two requests during SEND coalesce into one extra frame.
    push_frame(24'h00FF00, 24'h0000FF);
    push_frame(24'h00FF00, 24'h0000FF);
    pulse_req();
    tick();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    tick();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    drops = 0;
    restarts = 0;
    k = 0;
    while (n_done < 4 && k < 300) begin
      @(negedge clk);
      if (!busy && !frame_done) drops++;
      if (busy && frame_done) restarts++;
      tick();
      k++;
    end
    check("coalesce_done", 32'(n_done), 32'(4));
    check("coalesce_busy_drops", 32'(drops), 32'(0));
    check("coalesce_restart", 32'(restarts), 32'(1));
    repeat (L + 10) tick();
    check("coalesce_no_third", 32'(n_done), 32'(4));
    check("coalesce_idle", 32'(busy), 32'(0));

    // Out-of-range write completes and changes nothing.
    host_write(8'd2, 24'hFFFFFF);
    push_frame(24'h00FF00, 24'h0000FF);
    pulse_req();
    wait_done(5);
    tick();

    // Host write while busy.
    push_frame(24'h00FF00, 24'h0000FF);
    pulse_req();
    tick();
    wr_valid = 1'b1;
    wr_addr  = 8'd0;
    wr_grb   = 24'h123456;
`ifdef SK6812_DBUF_EN
    @(negedge clk);
    check("dbuf_wr_ready", 32'(wr_ready), 32'(1));
    check("dbuf_busy", 32'(busy), 32'(1));
    tick();
    wr_valid = 1'b0;
`else
    drops = 0;
    k = 0;
    ok = 1'b0;
    while (!ok && k < 300) begin
      @(negedge clk);
      ok = wr_ready;
      if (!ok && !busy) drops++;
      if (ok) check("stall_release_idle", 32'(busy), 32'(0));
      tick();
      k++;
    end
    wr_valid = 1'b0;
    check("stall_accepted", 32'(ok), 32'(1));
    check("stall_only_busy", 32'(drops), 32'(0));
    check("stall_waited", 32'(k > 5), 32'(1));
`endif
    wait_done(6);
    tick();
    push_frame(24'h123456, 24'h0000FF);
    pulse_req();
    wait_done(7);
    tick();

    // Reset in the middle of SEND.
    px_ready = 1'b0;
    pulse_req();
    tick();
    @(negedge clk);
    check("pre_rst_valid", 32'(px_valid), 32'(1));
    tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(px_valid), 32'(0));
    check("async_rst_busy", 32'(busy), 32'(0));
    tick();
    tick();
    rst_n = 1'b1;
    repeat (L + 10) tick();
    check("rst_no_done", 32'(n_done), 32'(7));
    px_ready = 1'b1;
    push_frame(24'h000000, 24'h000000);
    pulse_req();
    wait_done(8);
    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
